layer_seq: RTL and testbench

- Time-multiplexed successor to the fully parallel layer: computes SL nodes of a fully connected layer using P shared MAC lanes, iterating over the SX inputs.
- Weights and biases are held in an addressable word store rather than per-node shift registers; compute is controlled by a start/busy/done handshake.
- Sits between consecutive layers in the network datapath. The network controller loads parameters and triggers evaluation.

---
 rtl/layer_seq_if.sv | 20 ++
 rtl/layer_seq.sv | 120 ++++++++++++
 tb/tb_layer_seq.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/layer_seq_if.sv
// rtl/layer_seq_if.sv - parameter-load, start/busy/done and data bundle for layer_seq
interface layer_seq_if #(
   parameter int SX = 4,
   parameter int SL = 8,
   parameter int N  = 16
);
   localparam int AW = $clog2(SL * (SX + 1));

   logic              we;
   logic [AW-1:0]     waddr;
   logic [N-1:0]      wdata;
   logic              start;
   logic [N*SX-1:0]   nx;
   logic              busy;
   logic              done;
   logic [N*SL-1:0]   ly;

   modport master (output we, waddr, wdata, start, nx, input busy, done, ly);
   modport slave  (input we, waddr, wdata, start, nx, output busy, done, ly);
endinterface

// File: rtl/layer_seq.sv
// rtl/layer_seq.sv - time-multiplexed fully connected layer, SL nodes on P shared MAC lanes
// Optional macro LAYER_SEQ_RELU_EN selects ReLU activation instead of identity.
module layer_seq #(
   parameter int SX = 4,
   parameter int SL = 8,
   parameter int P  = 2,
   parameter int N  = 16,
   parameter int F  = 12
) (
   input  logic        clk,
   input  logic        rst,
   layer_seq_if.slave  bus
);
   localparam int NW   = SL * (SX + 1);
   localparam int AW   = $clog2(NW);
   localparam int G    = SL / P;
   localparam int GW   = (G > 1) ? $clog2(G) : 1;
   localparam int JW   = (SX > 1) ? $clog2(SX) : 1;
   localparam int ACCW = 2 * N + $clog2(SX + 1);

   typedef enum logic [1:0] {IDLE, ACC, FIN} state_t;

   state_t                 state;
   logic [GW-1:0]          g;
   logic [JW-1:0]          j;
   logic signed [N-1:0]    mem [NW];
   logic signed [N-1:0]    x_q [SX];
   logic signed [ACCW-1:0] acc [P];
   logic signed [ACCW-1:0] acc_nxt [P];
   logic [N-1:0]           act [P];
   logic                   busy_q;
   logic                   done_q;
   logic [N*SL-1:0]        ly_q;

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.ly   = ly_q;

   always_comb begin
      logic signed [N-1:0]    w;
      logic signed [N-1:0]    b;
      logic signed [2*N-1:0]  prod;
      logic signed [ACCW-1:0] sum;
      logic signed [ACCW-1:0] shr;
      logic [N-1:0]           res;
      int                     node;
      acc_nxt = '{default: '0};
      act     = '{default: '0};
      for (int p = 0; p < P; p++) begin
         node = int'(g) * P + p;
         w    = mem[AW'(node * (SX + 1) + int'(j))];
         b    = mem[AW'(node * (SX + 1) + SX)];
         prod = x_q[j] * w;
         acc_nxt[p] = acc[p] + {{(ACCW-2*N){prod[2*N-1]}}, prod};
         sum  = acc[p] + {{(ACCW-N-F){b[N-1]}}, b, {F{1'b0}}};
         shr  = sum >>> F;
         // In range when every bit above the N-bit sign position agrees with it.
         if ((&shr[ACCW-1:N-1]) || !(|shr[ACCW-1:N-1]))
            res = shr[N-1:0];
         else
            res = shr[ACCW-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`ifdef LAYER_SEQ_RELU_EN
         if (res[N-1])
            res = '0;
`endif
         act[p] = res;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         g      <= '0;
         j      <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         ly_q   <= '0;
         for (int i = 0; i < NW; i++) mem[i] <= '0;
         for (int i = 0; i < SX; i++) x_q[i] <= '0;
         for (int p = 0; p < P; p++)  acc[p] <= '0;
      end else begin
         done_q <= 1'b0;
         if (state == IDLE && bus.we && ({1'b0, bus.waddr} < (AW+1)'(NW)))
            mem[bus.waddr] <= bus.wdata;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  for (int i = 0; i < SX; i++) x_q[i] <= bus.nx[i*N +: N];
                  for (int p = 0; p < P; p++)  acc[p] <= '0;
                  g      <= '0;
                  j      <= '0;
                  busy_q <= 1'b1;
                  state  <= ACC;
               end
            end
            ACC: begin
               for (int p = 0; p < P; p++) acc[p] <= acc_nxt[p];
               if (j == JW'(SX - 1))
                  state <= FIN;
               else
                  j <= j + 1'b1;
            end
            FIN: begin
               for (int p = 0; p < P; p++) ly_q[(int'(g) * P + p) * N +: N] <= act[p];
               if (g == GW'(G - 1)) begin
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end else begin
                  for (int p = 0; p < P; p++) acc[p] <= '0;
                  g     <= g + 1'b1;
                  j     <= '0;
                  state <= ACC;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_layer_seq.sv
// tb/tb_layer_seq.sv - self-checking bench for layer_seq against an arithmetic reference model
module tb_layer_seq;
   localparam int SX = 4, SL = 8, P = 2, N = 16, F = 12;
   localparam int NW = SL * (SX + 1);
   localparam int L  = (SL / P) * (SX + 1);

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   tests = 0;
   int   fails = 0;
   bit   check_en = 1'b0;

   layer_seq_if #(.SX(SX), .SL(SL), .N(N)) bus ();
   layer_seq #(.SX(SX), .SL(SL), .P(P), .N(N), .F(F)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   logic [N-1:0]    m_mem [NW];
   logic [N*SX-1:0] m_x;
   logic [N*SL-1:0] m_ly;
   bit              m_busy, m_done;
   int              m_cnt;

   task automatic chk(input string name, input logic [N*SL-1:0] act, input logic [N*SL-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [N-1:0] node_val(input int k);
      longint s = 0;
      for (int jj = 0; jj < SX; jj++)
         s += longint'($signed(m_mem[k*(SX+1)+jj])) * longint'($signed(m_x[jj*N +: N]));
      s += longint'($signed(m_mem[k*(SX+1)+SX])) * (longint'(1) << F);
      s = s >>> F;
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
`ifdef LAYER_SEQ_RELU_EN
      if (s < 0) s = 0;
`endif
      return N'(s);
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_busy = 0; m_done = 0; m_cnt = 0; m_ly = '0; m_x = '0;
         for (int i = 0; i < NW; i++) m_mem[i] = '0;
      end else begin
         m_done = 0;
         if (m_busy) begin
            m_cnt++;
            if (m_cnt % (SX + 1) == 0)
               for (int p = 0; p < P; p++)
                  m_ly[((m_cnt/(SX+1)-1)*P + p)*N +: N] = node_val((m_cnt/(SX+1)-1)*P + p);
            if (m_cnt == L) begin m_busy = 0; m_done = 1; end
         end else begin
            if (bus.we && int'(bus.waddr) < NW) m_mem[bus.waddr] = bus.wdata;
            if (bus.start) begin m_x = bus.nx; m_busy = 1; m_cnt = 0; end
         end
      end
   end

   always @(negedge clk) begin
      if (rst && check_en) begin
         chk("cyc_busy", {{(N*SL-1){1'b0}}, bus.busy}, {{(N*SL-1){1'b0}}, m_busy});
         chk("cyc_done", {{(N*SL-1){1'b0}}, bus.done}, {{(N*SL-1){1'b0}}, m_done});
         chk("cyc_ly", bus.ly, m_ly);
      end
   end

   task automatic wr(input int addr, input logic [N-1:0] data);
      @(negedge clk);
      bus.we = 1'b1; bus.waddr = 6'(addr); bus.wdata = data;
      @(negedge clk);
      bus.we = 1'b0;
   endtask

   task automatic run(output int lat, output int bcnt);
      @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      lat = 0; bcnt = 0;
      while (!bus.done && lat <= 40) begin
         if (bus.busy) bcnt++;
         @(negedge clk); lat++;
      end
   endtask

   function automatic logic [N*SL-1:0] slot(input int k, input logic [N*SL-1:0] v);
      return {{(N*SL-N){1'b0}}, v[k*N +: N]};
   endfunction

   int lat, bcnt, dcount;
   logic [N-1:0] neg_sat, neg_small;

   initial begin
      bus.we = 0; bus.waddr = '0; bus.wdata = '0; bus.start = 0; bus.nx = '0;
`ifdef LAYER_SEQ_RELU_EN
      neg_sat = 16'h0000; neg_small = 16'h0000;
`else
      neg_sat = 16'h8000; neg_small = 16'hF800;
`endif
      repeat (2) @(negedge clk);
      chk("reset_busy", {127'b0, bus.busy}, '0);
      chk("reset_done", {127'b0, bus.done}, '0);
      chk("reset_ly", bus.ly, '0);
      rst = 1'b1;
      check_en = 1'b1;

      run(lat, bcnt);
      chk("empty_latency", 128'(lat), 128'(20));
      chk("empty_busy_cycles", 128'(bcnt), 128'(20));
      chk("empty_ly", bus.ly, '0);

      wr(0, 16'h1000); wr(4, 16'h0800);
      bus.nx = {48'h0, 16'h0400};
      run(lat, bcnt);
      chk("unit_ly0", slot(0, bus.ly), 128'h0C00);
      chk("unit_others", {bus.ly[N*SL-1:N], 16'h0}, '0);

      for (int k = 0; k < SL; k++) for (int jj = 0; jj < SX; jj++) wr(k*(SX+1)+jj, 16'h7FFF);
      bus.nx = {4{16'h7FFF}};
      run(lat, bcnt);
      for (int k = 0; k < SL; k++) chk($sformatf("sat_pos_%0d", k), slot(k, bus.ly), 128'h7FFF);

      for (int k = 0; k < SL; k++) for (int jj = 0; jj < SX; jj++) wr(k*(SX+1)+jj, 16'h8001);
      run(lat, bcnt);
      for (int k = 0; k < SL; k++) chk($sformatf("sat_neg_%0d", k), slot(k, bus.ly), 128'(neg_sat));

      wr(15, 16'hF000); wr(16, 16'h0); wr(17, 16'h0); wr(18, 16'h0);
      bus.nx = {48'h0, 16'h0800};
      run(lat, bcnt);
      chk("neg_node3", slot(3, bus.ly), 128'(neg_small));

      @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      lat = 0;
      while (!bus.done && lat <= 40) begin
         if (lat == 3) begin
            bus.start = 1'b1; bus.we = 1'b1; bus.waddr = 6'd4; bus.wdata = 16'h1000;
         end else begin
            bus.start = 1'b0; bus.we = 1'b0;
         end
         @(negedge clk); lat++;
      end
      bus.start = 1'b0; bus.we = 1'b0;
      chk("busy_ignore_latency", 128'(lat), 128'(20));
      run(lat, bcnt);
`ifdef LAYER_SEQ_RELU_EN
      chk("old_bias_ly0", slot(0, bus.ly), 128'h0000);
`else
      chk("old_bias_ly0", slot(0, bus.ly), 128'hC800);
`endif

      @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("abort_busy", {127'b0, bus.busy}, '0);
      chk("abort_done", {127'b0, bus.done}, '0);
      chk("abort_ly", bus.ly, '0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      dcount = 0;
      repeat (30) begin @(negedge clk); if (bus.done) dcount++; end
      chk("no_done_after_abort", 128'(dcount), '0);

      bus.nx = {4{16'h1234}};
      run(lat, bcnt);
      chk("cleared_params_latency", 128'(lat), 128'(20));
      chk("cleared_params_ly", bus.ly, '0);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
